uart_ctrl: RTL and testbench

- Memory-mapped controller that sequences the board UART for the MIPS32 pipeline's peripheral bus.
- Buffers CPU transmit bytes in a FIFO and issues one TX_SEND pulse per byte, paced by the UART's TX_STATUS handshake.
- Captures RX_STATUS/RX_DATA into a holding register with overrun detection.
- Raises an interrupt request for the CPU's exception logic.

---
 rtl/uart_ctrl_pkg.sv | 33 +++
 rtl/uart_ctrl_fifo.sv | 56 +++++
 rtl/uart_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
// Shared constants for the UART controller: register word offsets inside the
// peripheral window, STAT/CTRL bit positions and the TX sequencer state type.
package uart_ctrl_pkg;

  // Register word offsets (CPU byte address [3:2])
  localparam logic [1:0] ADDR_TXD  = 2'd0;
  localparam logic [1:0] ADDR_RXD  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // STAT bit positions; bits 4-6 are sticky and write-1-to-clear
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_BUSY  = 3;
  localparam int STAT_RX_OVR   = 4;
  localparam int STAT_TX_OVF   = 5;
  localparam int STAT_TX_TMO   = 6;

  // CTRL bit positions
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  // TX sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txState_e;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// uart_ctrl_fifo
// Synchronous byte FIFO buffering CPU transmit data.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset (empties the FIFO)
//   push_i      write pushData_i (caller guarantees room, or a same-cycle pop)
//   pushData_i  byte to store
//   pop_i       drop the head entry (caller guarantees non-empty)
//   headData_o  current head entry, combinational
//   full_o      all FIFO_DEPTH entries occupied
//   empty_o     no entries
module uart_ctrl_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] pushData_i,
  input  logic       pop_i,
  output logic [7:0] headData_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q;
  logic [AW:0] rdPtr_q;

  // The extra pointer MSB tells a full FIFO (MSBs differ) from an empty one
  // when the index bits coincide.
  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign headData_o = mem_q[rdPtr_q[AW-1:0]];

  // Pointer update; both may advance in one cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push_i) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (pop_i)  rdPtr_q <= rdPtr_q + PTR_ONE;
    end
  end

  // Storage. A push while full with a pop overwrites the slot being popped,
  // which is safe because the head was already read combinationally.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl
// Memory-mapped UART sequencer for the CPU peripheral bus. Buffers TX bytes,
// issues one tx_send pulse per byte paced by tx_status, captures received
// bytes with overrun detection and raises a level interrupt.
// Optional feature macro: UART_CTRL_IRQ_EN (interrupt enables and irq output;
// when undefined irq is 0 and CTRL reads 0).
// Ports:
//   sysclk     clock, rising edge
//   reset      synchronous active-low reset
//   addr       register word offset (TXD/RXD/STAT/CTRL)
//   wr_en      bus write strobe
//   rd_en      bus read strobe (only RXD reads have a side effect)
//   wdata      write data
//   rdata      read data, combinational from addr
//   tx_send    one-cycle send request to the UART
//   tx_data    byte to transmit, stable until the sequencer is back in IDLE
//   tx_status  UART TX idle flag
//   rx_status  one-cycle receive-done pulse
//   rx_data    received byte, valid with rx_status
//   irq        level interrupt request
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_status,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  txState_e      state_q;
  logic          txSend_q;
  logic [7:0]    txData_q;
  logic [CW-1:0] cnt_q;

  logic [7:0] rxHold_q, rxHold_d;
  logic       rxValid_q, rxValid_d;
  logic       rxOvr_q, rxOvr_d;
  logic       txOvf_q, txOvf_d;
  logic       txTmo_q, txTmo_d;

  logic        fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [7:0]  fifoHead;
  logic        txdWrite, statWrite, rxdRead, txDrop, tmoHit;
  logic [31:0] statWord, ctrlWord;
  logic        unusedWdata;

  assign unusedWdata = ^wdata[31:8];

  assign txdWrite  = wr_en && (addr == ADDR_TXD);
  assign statWrite = wr_en && (addr == ADDR_STAT);
  assign rxdRead   = rd_en && (addr == ADDR_RXD);

  // A same-cycle pop frees a slot, so a push into a full FIFO is only
  // dropped when the sequencer is not popping.
  assign fifoPop  = (state_q == IDLE) && !fifoEmpty && tx_status;
  assign fifoPush = txdWrite && (!fifoFull || fifoPop);
  assign txDrop   = txdWrite && fifoFull && !fifoPop;
  assign tmoHit   = (state_q == WAIT_BUSY) && tx_status && (cnt_q == CNT_LAST);

  uart_ctrl_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (sysclk),
    .rst_ni     (reset),
    .push_i     (fifoPush),
    .pushData_i (wdata[7:0]),
    .pop_i      (fifoPop),
    .headData_o (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  // TX sequencer. tx_send is registered, so it is high during the cycle after
  // the SEND state, which is also when the timeout counter starts from zero.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q  <= IDLE;
      txSend_q <= 1'b0;
      txData_q <= 8'h00;
      cnt_q    <= '0;
    end else begin
      txSend_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fifoPop) begin
            txData_q <= fifoHead;
            state_q  <= SEND;
          end
        end
        SEND: begin
          txSend_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_status)  state_q <= WAIT_DONE;
          else if (tmoHit) state_q <= IDLE;
          else             cnt_q   <= cnt_q + CNT_ONE;
        end
        WAIT_DONE: begin
          if (tx_status) state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_send = txSend_q;
  assign tx_data = txData_q;

  // RX holding register and sticky flags. Set events are applied after the
  // write-1-to-clear so that a set in the same cycle wins. A read that
  // coincides with a new byte consumes the old byte, so no overrun.
  always_comb begin
    rxHold_d  = rxHold_q;
    rxValid_d = rxValid_q;
    rxOvr_d   = rxOvr_q;
    txOvf_d   = txOvf_q;
    txTmo_d   = txTmo_q;
    if (statWrite) begin
      if (wdata[STAT_RX_OVR]) rxOvr_d = 1'b0;
      if (wdata[STAT_TX_OVF]) txOvf_d = 1'b0;
      if (wdata[STAT_TX_TMO]) txTmo_d = 1'b0;
    end
    if (rxdRead) rxValid_d = 1'b0;
    if (rx_status) begin
      rxHold_d  = rx_data;
      rxValid_d = 1'b1;
      if (rxValid_q && !rxdRead) rxOvr_d = 1'b1;
    end
    if (txDrop) txOvf_d = 1'b1;
    if (tmoHit) txTmo_d = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rxHold_q  <= 8'h00;
      rxValid_q <= 1'b0;
      rxOvr_q   <= 1'b0;
      txOvf_q   <= 1'b0;
      txTmo_q   <= 1'b0;
    end else begin
      rxHold_q  <= rxHold_d;
      rxValid_q <= rxValid_d;
      rxOvr_q   <= rxOvr_d;
      txOvf_q   <= txOvf_d;
      txTmo_q   <= txTmo_d;
    end
  end

`ifdef UART_CTRL_IRQ_EN
  logic rxIe_q;
  logic txIe_q;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rxIe_q <= 1'b0;
      txIe_q <= 1'b0;
    end else if (wr_en && (addr == ADDR_CTRL)) begin
      rxIe_q <= wdata[CTRL_RX_IE];
      txIe_q <= wdata[CTRL_TX_IE];
    end
  end

  always_comb begin
    ctrlWord             = '0;
    ctrlWord[CTRL_RX_IE] = rxIe_q;
    ctrlWord[CTRL_TX_IE] = txIe_q;
  end

  assign irq = (rxIe_q & rxValid_q) | (txIe_q & fifoEmpty & (state_q == IDLE));
`else
  assign ctrlWord = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    statWord                = '0;
    statWord[STAT_RX_VALID] = rxValid_q;
    statWord[STAT_TX_FULL]  = fifoFull;
    statWord[STAT_TX_EMPTY] = fifoEmpty;
    statWord[STAT_TX_BUSY]  = (state_q != IDLE);
    statWord[STAT_RX_OVR]   = rxOvr_q;
    statWord[STAT_TX_OVF]   = txOvf_q;
    statWord[STAT_TX_TMO]   = txTmo_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_RXD:  rdata = {24'b0, rxHold_q};
      ADDR_STAT: rdata = statWord;
      ADDR_CTRL: rdata = ctrlWord;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl
// Directed bench for uart_ctrl. A small UART model answers each tx_send pulse
// by dropping tx_status 3 cycles later and raising it 100 cycles after that;
// every pulsed byte is logged in order. Inputs change on the falling edge and
// outputs are sampled there (or 1 ns later for combinational reads).
module tb_uart_ctrl;

   localparam int TMO = 8192;

   logic        sysclk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        tx_send;
   logic [7:0]  tx_data;
   logic        tx_status;
   logic        rx_status = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        irq;

   logic        uartMode = 1'b0;
   logic        forceStatus = 1'b1;
   logic        autoStatus = 1'b1;
   int          modelCnt = 0;
   int          pulseCnt = 0;
   logic [7:0]  sentQ[$];

   int total = 0;
   int bad = 0;

   assign tx_status = uartMode ? autoStatus : forceStatus;

   uart_ctrl #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .addr      (addr),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .wdata     (wdata),
      .rdata     (rdata),
      .tx_send   (tx_send),
      .tx_data   (tx_data),
      .tx_status (tx_status),
      .rx_status (rx_status),
      .rx_data   (rx_data),
      .irq       (irq)
   );

   always #5 sysclk = ~sysclk;

   // UART model and send log
   always @(negedge sysclk) begin
      if (tx_send === 1'b1) begin
         sentQ.push_back(tx_data);
         pulseCnt++;
         modelCnt = 1;
      end else if (modelCnt > 0) begin
         modelCnt++;
         if (modelCnt == 4) autoStatus = 1'b0;
         else if (modelCnt == 104) begin
            autoStatus = 1'b1;
            modelCnt = 0;
         end
      end
   end

   // Watchdog so a stuck design still ends the run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
      addr = a;
      #1;
      checkOutput(tag, rdata, expected);
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      wr_en = 1'b1;
      @(negedge sysclk);
      wr_en = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      rd_en = 1'b1;
      #1;
      d = rdata;
      @(negedge sysclk);
      rd_en = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] d);
      rx_data = d;
      rx_status = 1'b1;
      @(negedge sysclk);
      rx_status = 1'b0;
   endtask

   // Wait until the FIFO is empty and the sequencer is idle
   task automatic waitDrain(input string tag, input int budget);
      int n;
      logic [31:0] s;
      n = 0;
      addr = 2'd2;
      #1;
      s = rdata;
      while (!(s[2] && !s[3]) && n < budget) begin
         @(negedge sysclk);
         #1;
         s = rdata;
         n++;
      end
      checkOutput(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      int base;

      // Reset
      tick(3);
      reset = 1'b1;
      checkReg("resetStat", 2'd2, 32'h0000_0004);
      checkOutput("resetIrq", {31'b0, irq}, 32'd0);
      checkOutput("resetTxSend", {31'b0, tx_send}, 32'd0);
      checkOutput("resetTxData", {24'b0, tx_data}, 32'd0);
      checkReg("resetRxd", 2'd1, 32'd0);

      // Single byte with UART handshake
      uartMode = 1'b1;
      busWrite(2'd0, 32'h41);
      checkReg("oneQueued", 2'd2, 32'h0000_0000);
      checkOutput("oneNoSend0", {31'b0, tx_send}, 32'd0);
      tick(1);
      checkOutput("oneNoSend1", {31'b0, tx_send}, 32'd0);
      checkReg("oneBusyEarly", 2'd2, 32'h0000_000C);
      tick(1);
      checkOutput("oneSend", {31'b0, tx_send}, 32'd1);
      checkOutput("oneData", {24'b0, tx_data}, 32'h41);
      tick(1);
      checkOutput("oneSendLow", {31'b0, tx_send}, 32'd0);
      tick(47);
      checkReg("oneBusyMid", 2'd2, 32'h0000_000C);
      tick(100);
      checkReg("oneDone", 2'd2, 32'h0000_0004);
      checkOutput("onePulses", pulseCnt, 1);

      // Overflow: nine writes with the UART busy
      uartMode = 1'b0;
      forceStatus = 1'b0;
      tick(1);
      base = sentQ.size();
      for (int i = 0; i < 9; i++) busWrite(2'd0, i);
      checkReg("ovfStat", 2'd2, 32'h0000_0022);
      uartMode = 1'b1;
      waitDrain("ovfDrain", 3000);
      checkOutput("ovfCount", sentQ.size() - base, 8);
      for (int i = 0; i < 8; i++)
         if (base + i < sentQ.size())
            checkOutput($sformatf("ovfByte%0d", i), {24'b0, sentQ[base + i]}, i);
      checkReg("ovfSticky", 2'd2, 32'h0000_0024);
      busWrite(2'd2, 32'h20);
      checkReg("ovfClear", 2'd2, 32'h0000_0004);

      // Push while full with a same-cycle pop
      uartMode = 1'b0;
      forceStatus = 1'b0;
      tick(1);
      base = sentQ.size();
      for (int i = 0; i < 8; i++) busWrite(2'd0, 32'h10 + i);
      checkReg("fullStat", 2'd2, 32'h0000_0002);
      addr = 2'd0;
      wdata = 32'h18;
      wr_en = 1'b1;
      forceStatus = 1'b1;
      @(negedge sysclk);
      wr_en = 1'b0;
      forceStatus = 1'b0;
      checkReg("fullPushPop", 2'd2, 32'h0000_000A);
      uartMode = 1'b1;
      waitDrain("fullDrain", 3000);
      checkOutput("fullCount", sentQ.size() - base, 9);
      for (int i = 0; i < 9; i++)
         if (base + i < sentQ.size())
            checkOutput($sformatf("fullByte%0d", i), {24'b0, sentQ[base + i]}, 32'h10 + i);
      checkReg("fullNoOvf", 2'd2, 32'h0000_0004);

      // RX overrun and W1C
      applyStimulus(8'h55);
      applyStimulus(8'hAA);
      checkReg("rxOvrStat", 2'd2, 32'h0000_0015);
      busRead(2'd1, d);
      checkOutput("rxOvrData", d, 32'hAA);
      checkReg("rxAfterRead", 2'd2, 32'h0000_0014);
      busWrite(2'd2, 32'h10);
      checkReg("rxOvrClear", 2'd2, 32'h0000_0004);

      // RX pulse coinciding with an RXD read
      applyStimulus(8'h11);
      checkReg("rxValid", 2'd2, 32'h0000_0005);
      addr = 2'd1;
      rd_en = 1'b1;
      rx_data = 8'h22;
      rx_status = 1'b1;
      #1;
      d = rdata;
      @(negedge sysclk);
      rd_en = 1'b0;
      rx_status = 1'b0;
      checkOutput("rxSameOld", d, 32'h11);
      checkReg("rxSameStat", 2'd2, 32'h0000_0005);
      checkReg("rxSameNew", 2'd1, 32'h22);

      // Overrun set collides with W1C: set wins
      addr = 2'd2;
      wdata = 32'h10;
      wr_en = 1'b1;
      rx_data = 8'h33;
      rx_status = 1'b1;
      @(negedge sysclk);
      wr_en = 1'b0;
      rx_status = 1'b0;
      checkReg("setWinsStat", 2'd2, 32'h0000_0015);
      checkReg("setWinsData", 2'd1, 32'h33);
      busRead(2'd1, d);
      busWrite(2'd2, 32'h10);
      checkReg("rxCleanStat", 2'd2, 32'h0000_0004);

      // TX timeout with tx_status stuck high
      uartMode = 1'b0;
      forceStatus = 1'b1;
      busWrite(2'd0, 32'hA5);
      tick(2);
      checkOutput("tmoSend", {31'b0, tx_send}, 32'd1);
      checkOutput("tmoData", {24'b0, tx_data}, 32'hA5);
      tick(TMO - 1);
      checkReg("tmoBefore", 2'd2, 32'h0000_000C);
      tick(1);
      checkReg("tmoSet", 2'd2, 32'h0000_0044);
      uartMode = 1'b1;
      busWrite(2'd0, 32'h5A);
      tick(2);
      checkOutput("tmoNextSend", {31'b0, tx_send}, 32'd1);
      checkOutput("tmoNextData", {24'b0, tx_data}, 32'h5A);
      waitDrain("tmoDrain", 500);
      busWrite(2'd2, 32'h40);
      checkReg("tmoClear", 2'd2, 32'h0000_0004);
      checkOutput("pulseTotal", pulseCnt, 20);

      // Interrupts
`ifdef UART_CTRL_IRQ_EN
      busWrite(2'd3, 32'h1);
      checkReg("ctrlRx", 2'd3, 32'h1);
      checkOutput("irqIdle", {31'b0, irq}, 32'd0);
      applyStimulus(8'h33);
      checkOutput("irqRx", {31'b0, irq}, 32'd1);
      busRead(2'd1, d);
      checkOutput("irqRxData", d, 32'h33);
      checkOutput("irqRxCleared", {31'b0, irq}, 32'd0);
      busWrite(2'd3, 32'h2);
      checkOutput("irqTxEmpty", {31'b0, irq}, 32'd1);
      busWrite(2'd3, 32'h0);
      checkOutput("irqOff", {31'b0, irq}, 32'd0);
`else
      busWrite(2'd3, 32'h3);
      checkReg("ctrlTiedZero", 2'd3, 32'h0);
      applyStimulus(8'h33);
      checkOutput("irqTiedZero", {31'b0, irq}, 32'd0);
      busRead(2'd1, d);
      checkOutput("irqRxData", d, 32'h33);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
